// File: rtl/game_sequencer.sv
// game_sequencer
//   Game flow controller for the frogger-style datapath. Walks the game through
//   ATTRACT, PLAY, HIT (collision recovery), CLEAR (level cleared) and OVER.
//   It owns the remaining lives, the BCD level count and the car speed.
//   It also tells the player datapath when to respawn and when moves are accepted.
//
// Ports
//   CLK, RST_N      clock, asynchronous active-low reset
//   i_frame_tick    one pulse per video frame
//   i_start         start game from ATTRACT
//   i_restart       restart from any state (highest priority)
//   i_collision     player/car overlap (acted on in PLAY only)
//   i_reached_top   player reached the top row (acted on in PLAY only)
//   o_state         0 ATTRACT, 1 PLAY, 2 HIT, 3 CLEAR, 4 OVER
//   o_player_reset  one-cycle respawn pulse
//   o_move_en       player may move (PLAY)
//   o_cars_en       cars advance (PLAY, HIT)
//   o_blink         sprite hide strobe during HIT
//   o_lives         thermometer of remaining lives
//   o_tens, o_units BCD level 00..99
//   o_speed_car     car speed index, saturating at SPEED_MAX
module game_sequencer #(
   parameter int unsigned LIVES        = 4,
   parameter int unsigned HIT_FRAMES   = 60,
   parameter int unsigned CLEAR_FRAMES = 30,
   parameter int unsigned OVER_FRAMES  = 120,
   parameter int unsigned SPEED_MAX    = 31
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             i_frame_tick,
   input  logic             i_start,
   input  logic             i_restart,
   input  logic             i_collision,
   input  logic             i_reached_top,
   output logic [2:0]       o_state,
   output logic             o_player_reset,
   output logic             o_move_en,
   output logic             o_cars_en,
   output logic             o_blink,
   output logic [LIVES-1:0] o_lives,
   output logic [3:0]       o_tens,
   output logic [3:0]       o_units,
   output logic [4:0]       o_speed_car
);

   localparam int unsigned MAX_HC     = (HIT_FRAMES > CLEAR_FRAMES) ? HIT_FRAMES : CLEAR_FRAMES;
   localparam int unsigned MAX_FRAMES = (MAX_HC > OVER_FRAMES) ? MAX_HC : OVER_FRAMES;
   // At least 3 bits so the blink strobe bit always exists.
   localparam int unsigned CNT_W      = ($clog2(MAX_FRAMES) < 3) ? 3 : $clog2(MAX_FRAMES);

   typedef enum logic [2:0] {
      S_ATTRACT = 3'd0,
      S_PLAY    = 3'd1,
      S_HIT     = 3'd2,
      S_CLEAR   = 3'd3,
      S_OVER    = 3'd4
   } state_t;

   state_t             r_state,        w_state_nxt;
   logic [CNT_W-1:0]   r_frame_cnt,    w_cnt_nxt;
   logic [LIVES-1:0]   r_lives,        w_lives_nxt;
   logic [3:0]         r_tens,         w_tens_nxt;
   logic [3:0]         r_units,        w_units_nxt;
   logic [4:0]         r_speed,        w_speed_nxt;
   logic               r_player_reset, w_preset_nxt;
   logic               r_move_en,      w_move_en_nxt;
   logic               r_cars_en,      w_cars_en_nxt;
   logic               r_blink,        w_blink_nxt;
   logic               w_cnt_last;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state        <= S_ATTRACT;
         r_frame_cnt    <= '0;
         r_lives        <= '1;
         r_tens         <= '0;
         r_units        <= '0;
         r_speed        <= '0;
         r_player_reset <= 1'b0;
         r_move_en      <= 1'b0;
         r_cars_en      <= 1'b0;
         r_blink        <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_frame_cnt    <= w_cnt_nxt;
         r_lives        <= w_lives_nxt;
         r_tens         <= w_tens_nxt;
         r_units        <= w_units_nxt;
         r_speed        <= w_speed_nxt;
         r_player_reset <= w_preset_nxt;
         r_move_en      <= w_move_en_nxt;
         r_cars_en      <= w_cars_en_nxt;
         r_blink        <= w_blink_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_frame_cnt;
      w_lives_nxt  = r_lives;
      w_tens_nxt   = r_tens;
      w_units_nxt  = r_units;
      w_speed_nxt  = r_speed;
      w_preset_nxt = 1'b0;

      // Last frame of the current timed phase.
      case (r_state)
         S_HIT:   w_cnt_last = (r_frame_cnt == CNT_W'(HIT_FRAMES - 1));
         S_CLEAR: w_cnt_last = (r_frame_cnt == CNT_W'(CLEAR_FRAMES - 1));
         S_OVER:  w_cnt_last = (r_frame_cnt == CNT_W'(OVER_FRAMES - 1));
         default: w_cnt_last = 1'b0;
      endcase

      if (i_restart) begin
         w_state_nxt  = S_PLAY;
         w_cnt_nxt    = '0;
         w_lives_nxt  = '1;
         w_tens_nxt   = '0;
         w_units_nxt  = '0;
         w_speed_nxt  = '0;
         w_preset_nxt = 1'b1;
      end else begin
         case (r_state)
            S_ATTRACT: begin
               if (i_start) begin
                  w_state_nxt  = S_PLAY;
                  w_preset_nxt = 1'b1;
               end
            end
            S_PLAY: begin
               if (i_collision) begin
                  w_cnt_nxt    = '0;
                  w_preset_nxt = 1'b1;
                  if (r_lives == LIVES'(1)) begin
                     w_state_nxt = S_OVER;
                     w_lives_nxt = '0;
                  end else begin
                     w_state_nxt = S_HIT;
                     w_lives_nxt = r_lives >> 1;
                  end
               end else if (i_reached_top) begin
                  w_cnt_nxt    = '0;
                  w_preset_nxt = 1'b1;
                  w_state_nxt  = S_CLEAR;
                  // BCD increment, holding at 99.
                  if (!(r_tens == 4'd9 && r_units == 4'd9)) begin
                     if (r_units == 4'd9) begin
                        w_units_nxt = '0;
                        w_tens_nxt  = r_tens + 4'd1;
                     end else begin
                        w_units_nxt = r_units + 4'd1;
                     end
                  end
                  if (r_speed != 5'(SPEED_MAX))
                     w_speed_nxt = r_speed + 5'd1;
               end
            end
            S_HIT, S_CLEAR, S_OVER: begin
               if (i_frame_tick) begin
                  if (w_cnt_last) begin
                     w_cnt_nxt = '0;
                     if (r_state == S_OVER) begin
                        w_state_nxt = S_ATTRACT;
                        w_lives_nxt = '1;
                        w_tens_nxt  = '0;
                        w_units_nxt = '0;
                        w_speed_nxt = '0;
                     end else begin
                        w_state_nxt = S_PLAY;
                     end
                  end else begin
                     w_cnt_nxt = r_frame_cnt + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = S_ATTRACT;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      // Enables and blink are derived from the next state so they register
      // in the same cycle as the state they belong to.
      w_move_en_nxt = (w_state_nxt == S_PLAY);
      w_cars_en_nxt = (w_state_nxt == S_PLAY) || (w_state_nxt == S_HIT);
      w_blink_nxt   = (w_state_nxt == S_HIT) && w_cnt_nxt[2];
   end

   assign o_state        = r_state;
   assign o_player_reset = r_player_reset;
   assign o_move_en      = r_move_en;
   assign o_cars_en      = r_cars_en;
   assign o_blink        = r_blink;
   assign o_lives        = r_lives;
   assign o_tens         = r_tens;
   assign o_units        = r_units;
   assign o_speed_car    = r_speed;

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: a frame-level game model is checked against
// the DUT every cycle, plus literal expectations at key scenario points.
module tb_game_sequencer;

   localparam int LIVES = 4;
   localparam int HITF  = 60;
   localparam int CLRF  = 30;
   localparam int OVRF  = 120;
   localparam int SPMAX = 31;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_frame_tick = 1'b0;
   logic       i_start = 1'b0;
   logic       i_restart = 1'b0;
   logic       i_collision = 1'b0;
   logic       i_reached_top = 1'b0;
   logic [2:0] o_state;
   logic       o_player_reset, o_move_en, o_cars_en, o_blink;
   logic [LIVES-1:0] o_lives;
   logic [3:0] o_tens, o_units;
   logic [4:0] o_speed_car;

   int n_checks = 0;
   int n_err    = 0;

   game_sequencer #(
      .LIVES(LIVES), .HIT_FRAMES(HITF), .CLEAR_FRAMES(CLRF),
      .OVER_FRAMES(OVRF), .SPEED_MAX(SPMAX)
   ) dut (
      .CLK(clk), .RST_N(rst_n),
      .i_frame_tick(i_frame_tick), .i_start(i_start), .i_restart(i_restart),
      .i_collision(i_collision), .i_reached_top(i_reached_top),
      .o_state(o_state), .o_player_reset(o_player_reset), .o_move_en(o_move_en),
      .o_cars_en(o_cars_en), .o_blink(o_blink), .o_lives(o_lives),
      .o_tens(o_tens), .o_units(o_units), .o_speed_car(o_speed_car)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Game model: phase number, lives as a count, level as an integer,
   // frames elapsed in the current timed phase.
   int m_state = 0, m_lives = LIVES, m_level = 0, m_speed = 0, m_frames = 0;
   bit m_respawn = 0;

   function automatic int phase_len(input int st);
      if (st == 2) return HITF;
      if (st == 3) return CLRF;
      return OVRF;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_lives = LIVES; m_level = 0; m_speed = 0;
         m_frames = 0; m_respawn = 0;
      end else begin
         m_respawn = 0;
         if (i_restart) begin
            m_state = 1; m_lives = LIVES; m_level = 0; m_speed = 0;
            m_frames = 0; m_respawn = 1;
         end else if (m_state == 0) begin
            if (i_start) begin m_state = 1; m_respawn = 1; end
         end else if (m_state == 1) begin
            if (i_collision) begin
               m_lives  = m_lives - 1;
               m_state  = (m_lives == 0) ? 4 : 2;
               m_frames = 0; m_respawn = 1;
            end else if (i_reached_top) begin
               m_level  = (m_level < 99) ? m_level + 1 : 99;
               m_speed  = (m_speed < SPMAX) ? m_speed + 1 : SPMAX;
               m_state  = 3; m_frames = 0; m_respawn = 1;
            end
         end else if (i_frame_tick) begin
            m_frames++;
            if (m_frames == phase_len(m_state)) begin
               m_frames = 0;
               if (m_state == 4) begin
                  m_state = 0; m_lives = LIVES; m_level = 0; m_speed = 0;
               end else begin
                  m_state = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("state",   int'(o_state),        m_state);
      chk("respawn", int'(o_player_reset), int'(m_respawn));
      chk("move_en", int'(o_move_en),      int'(m_state == 1));
      chk("cars_en", int'(o_cars_en),      int'(m_state == 1 || m_state == 2));
      chk("blink",   int'(o_blink),        int'(m_state == 2 && ((m_frames / 4) % 2 == 1)));
      chk("lives",   int'(o_lives),        (1 << m_lives) - 1);
      chk("tens",    int'(o_tens),         m_level / 10);
      chk("units",   int'(o_units),        m_level % 10);
      chk("speed",   int'(o_speed_car),    m_speed);
   end

   // Hold the given inputs for exactly one rising edge.
   task automatic drive(input bit s, input bit r, input bit c, input bit t);
      i_start = s; i_restart = r; i_collision = c; i_reached_top = t;
      @(posedge clk); #2;
      i_start = 0; i_restart = 0; i_collision = 0; i_reached_top = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         i_frame_tick = 1'b1;
         @(posedge clk); #2;
      end
      i_frame_tick = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset values.
      chk("rst_state", int'(o_state), 0);
      chk("rst_lives", int'(o_lives), 15);
      chk("rst_speed", int'(o_speed_car), 0);

      // Top pulse in ATTRACT ignored.
      drive(0, 0, 0, 1);
      chk("attract_top_state", int'(o_state), 0);
      chk("attract_top_units", int'(o_units), 0);

      // Start.
      drive(1, 0, 0, 0);
      chk("start_state", int'(o_state), 1);
      chk("start_pulse", int'(o_player_reset), 1);
      chk("start_lives", int'(o_lives), 15);
      @(posedge clk); #2;
      chk("start_pulse_end", int'(o_player_reset), 0);

      // First collision and HIT timing.
      drive(0, 0, 1, 0);
      chk("hit_state", int'(o_state), 2);
      chk("hit_lives", int'(o_lives), 7);
      chk("hit_move", int'(o_move_en), 0);
      ticks(3);
      chk("hit_blink3", int'(o_blink), 0);
      ticks(1);
      chk("hit_blink4", int'(o_blink), 1);
      ticks(55);
      chk("hit_59", int'(o_state), 2);
      ticks(1);
      chk("hit_60", int'(o_state), 1);

      // Collisions down to game over; collision in HIT ignored.
      drive(0, 0, 1, 0);
      drive(0, 0, 1, 0);
      chk("hit_ignore_lives", int'(o_lives), 3);
      ticks(HITF);
      drive(0, 0, 1, 0);
      chk("lives_one", int'(o_lives), 1);
      ticks(HITF);
      drive(0, 0, 1, 0);
      chk("over_state", int'(o_state), 4);
      chk("over_lives", int'(o_lives), 0);
      ticks(119);
      chk("over_119", int'(o_state), 4);
      ticks(1);
      chk("attract_state", int'(o_state), 0);
      chk("attract_lives", int'(o_lives), 15);

      // Level counting and speed saturation.
      drive(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, 0, 1);
         if (i == 0) chk("clear_state", int'(o_state), 3);
         ticks(CLRF);
      end
      chk("lvl9_units", int'(o_units), 9);
      chk("lvl9_tens", int'(o_tens), 0);
      chk("lvl9_speed", int'(o_speed_car), 9);
      drive(0, 0, 0, 1);
      chk("lvl10_tens", int'(o_tens), 1);
      chk("lvl10_units", int'(o_units), 0);
      chk("lvl10_speed", int'(o_speed_car), 10);
      ticks(CLRF - 1);
      chk("clear_29", int'(o_state), 3);
      ticks(1);
      chk("clear_30", int'(o_state), 1);
      for (int i = 0; i < 90; i++) begin
         drive(0, 0, 0, 1);
         ticks(CLRF);
      end
      chk("lvl99_tens", int'(o_tens), 9);
      chk("lvl99_units", int'(o_units), 9);
      chk("lvl99_speed", int'(o_speed_car), 31);
      chk("lvl99_state", int'(o_state), 1);

      // Collision beats reached_top in the same cycle.
      drive(0, 0, 1, 1);
      chk("both_state", int'(o_state), 2);
      chk("both_tens", int'(o_tens), 9);
      chk("both_units", int'(o_units), 9);
      chk("both_lives", int'(o_lives), 7);
      ticks(HITF);

      // Restart during OVER.
      drive(0, 0, 1, 0);
      ticks(HITF);
      drive(0, 0, 1, 0);
      ticks(HITF);
      drive(0, 0, 1, 0);
      chk("over2_state", int'(o_state), 4);
      ticks(50);
      drive(0, 1, 0, 0);
      chk("restart_state", int'(o_state), 1);
      chk("restart_lives", int'(o_lives), 15);
      chk("restart_tens", int'(o_tens), 0);
      chk("restart_units", int'(o_units), 0);
      chk("restart_speed", int'(o_speed_car), 0);
      chk("restart_pulse", int'(o_player_reset), 1);

      // Asynchronous reset mid-HIT.
      drive(0, 0, 1, 0);
      ticks(10);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_state", int'(o_state), 0);
      chk("arst_lives", int'(o_lives), 15);
      chk("arst_pulse", int'(o_player_reset), 0);
      chk("arst_cars", int'(o_cars_en), 0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #2;
      drive(1, 0, 0, 0);
      chk("post_rst_start", int'(o_state), 1);
      @(posedge clk); #2;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
